// File: rtl/connect4_pkg.sv
// Purpose : shared command encoding, UART byte codes and key indices for the connect-4 input front end.
// Latency : n/a (types, constants and a pure decode function only).
// Backpres: n/a.
package connect4_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_ACCEPT,
    CMD_RESET
  } cmd_e;

  typedef enum logic {
    WIN_IDLE,
    WIN_WAIT
  } win_state_e;

  localparam logic [7:0] UART_RIGHT  = 8'h01;
  localparam logic [7:0] UART_LEFT   = 8'h02;
  localparam logic [7:0] UART_ACCEPT = 8'h03;
  localparam logic [7:0] UART_RESET  = 8'h04;

  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_ACCEPT = 2;
  localparam int KEY_RESET  = 3;

  // Map a received UART byte onto a command; unknown bytes are ignored.
  function automatic cmd_e uart_decode(input logic [7:0] b);
    case (b)
      UART_RIGHT:  return CMD_RIGHT;
      UART_LEFT:   return CMD_LEFT;
      UART_ACCEPT: return CMD_ACCEPT;
      UART_RESET:  return CMD_RESET;
      default:     return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Purpose : one raw active-low key -> 2-flop sync -> stable-count debounce -> registered press pulse.
// Latency : press pulse 2 (sync) + DEBOUNCE_CYC + 1 cycles after the raw key settles low.
// Backpres: none; free-running, pulse is a 1-cycle strobe.
// Ports   : clk, rstn (async active-low), key_n (raw, asynchronous), press (1-cycle released->pressed pulse).
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 250_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_n;      // sync_n[1] is the synchronised key
  logic          deb_n;       // debounced level, 1 = released
  logic          deb_prev_n;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_n     <= 2'b11;
      deb_n      <= 1'b1;
      deb_prev_n <= 1'b1;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      sync_n     <= {sync_n[0], key_n};
      deb_prev_n <= deb_n;
      // Edge of the debounced level, registered: lands the cycle after the level update.
      press      <= deb_prev_n & ~deb_n;
      // Count consecutive cycles the synced input disagrees with the debounced level;
      // any agreeing cycle restarts the count.
      if (sync_n[1] != deb_n) begin
        if (cnt == CNT_LAST) begin
          deb_n <= sync_n[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/game_input_ctrl.sv
// Purpose : connect-4 input/timing front end: debounced keys + UART commands -> move/reset pulses,
//           per-turn countdown with auto-move, delayed post-win game reset.
// Latency : move/reset pulses 1 cycle after btn_pulse or uart_valid; win reset WIN_DELAY_CYC after win_flag rise.
// Backpres: none; all outputs are 1-cycle strobes, requests arriving together are arbitrated, not queued.
// Ports   : clk, rstn, key_n[NUM_BTN], uart_valid, uart_data[8], turn_active, win_flag ->
//           move_left, move_right, move_made, times_up, game_reset, btn_pulse[NUM_BTN], turn_secs[4].
module game_input_ctrl
  import connect4_pkg::*;
#(
  parameter int CLK_HZ        = 25_000_000,
  parameter int NUM_BTN       = 4,
  parameter int DEBOUNCE_CYC  = 250_000,
  parameter int TURN_SEC      = 10,
  parameter int WIN_DELAY_CYC = 12_500_000,
  parameter int UART_EN       = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_BTN-1:0] key_n,
  input  logic               uart_valid,
  input  logic [7:0]         uart_data,
  input  logic               turn_active,
  input  logic               win_flag,
  output logic               move_left,
  output logic               move_right,
  output logic               move_made,
  output logic               times_up,
  output logic               game_reset,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [3:0]         turn_secs
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int WW = $clog2(WIN_DELAY_CYC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [3:0]    SECS_MAX   = 4'(TURN_SEC);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_DELAY_CYC - 1);

  // ---------------- key conditioning ----------------
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
      .clk  (clk),
      .rstn (rstn),
      .key_n(key_n[i]),
      .press(btn_pulse[i])
    );
  end

  // ---------------- request merge ----------------
  cmd_e uart_cmd;
  logic req_left, req_right, req_accept, req_reset;

  always_comb begin
    uart_cmd = CMD_NONE;
    if (UART_EN != 0 && uart_valid) uart_cmd = uart_decode(uart_data);
    // Key and UART asking for the same thing in one cycle collapse into one request.
    req_left   = btn_pulse[KEY_LEFT]   || (uart_cmd == CMD_LEFT);
    req_right  = btn_pulse[KEY_RIGHT]  || (uart_cmd == CMD_RIGHT);
    req_accept = btn_pulse[KEY_ACCEPT] || (uart_cmd == CMD_ACCEPT);
    req_reset  = btn_pulse[KEY_RESET]  || (uart_cmd == CMD_RESET);
  end

  // ---------------- turn timer ----------------
  logic [PW-1:0] presc;
  logic          timer_clr, presc_wrap, timeout_evt;

  // Registered move_made/game_reset clear the timer, so the clear lands the cycle after the pulse.
  assign timer_clr  = move_made | game_reset;
  assign presc_wrap = turn_active && (presc == PRESC_LAST);
  // Fires only on the step into TURN_SEC; saturation prevents a repeat until the timer is cleared.
  assign timeout_evt = presc_wrap && !timer_clr && (turn_secs == SECS_MAX - 4'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc     <= '0;
      turn_secs <= '0;
    end else if (timer_clr) begin
      presc     <= '0;
      turn_secs <= '0;
    end else if (turn_active) begin
      if (presc_wrap) begin
        presc <= '0;
        if (turn_secs != SECS_MAX) turn_secs <= turn_secs + 4'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // ---------------- post-win delay FSM ----------------
  win_state_e    win_state, win_state_nx;
  logic [WW-1:0] win_cnt, win_cnt_nx;
  logic          win_prev;
  logic          win_fire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_state <= WIN_IDLE;
      win_cnt   <= '0;
      // Treated as already high so a win_flag held high across reset is not seen as a new win.
      win_prev  <= 1'b1;
    end else begin
      win_state <= win_state_nx;
      win_cnt   <= win_cnt_nx;
      win_prev  <= win_flag;
    end
  end

  always_comb begin
    win_state_nx = win_state;
    win_cnt_nx   = win_cnt;
    win_fire     = 1'b0;
    case (win_state)
      WIN_IDLE: begin
        if (win_flag && !win_prev) begin
          // The rise cycle itself is count 0, so the next cycle holds count 1.
          win_state_nx = WIN_WAIT;
          win_cnt_nx   = WW'(1);
        end
      end
      WIN_WAIT: begin
        if (win_cnt == WIN_LAST) begin
          win_fire     = 1'b1;
          win_state_nx = WIN_IDLE;
          win_cnt_nx   = '0;
        end else if (req_reset) begin
          win_state_nx = WIN_IDLE;
          win_cnt_nx   = '0;
        end else begin
          win_cnt_nx = win_cnt + 1'b1;
        end
      end
      default: begin
        win_state_nx = WIN_IDLE;
        win_cnt_nx   = '0;
      end
    endcase
  end

  // ---------------- arbitration + output registers ----------------
  logic nx_left, nx_right, nx_made, nx_times_up, nx_reset, allow_move;

  always_comb begin
    nx_reset    = req_reset || win_fire;
    // Reset wins outright; the win wait blocks every move source including timeout.
    allow_move  = !nx_reset && (win_state != WIN_WAIT);
    nx_left     = allow_move && req_left  && !req_right && !req_accept;
    nx_right    = allow_move && req_right && !req_left  && !req_accept;
    nx_made     = allow_move && (req_accept || timeout_evt);
    nx_times_up = allow_move && timeout_evt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
      move_made  <= 1'b0;
      times_up   <= 1'b0;
      game_reset <= 1'b0;
    end else begin
      move_left  <= nx_left;
      move_right <= nx_right;
      move_made  <= nx_made;
      times_up   <= nx_times_up;
      game_reset <= nx_reset;
    end
  end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Purpose : directed self-checking bench for game_input_ctrl with small timing parameters.
// Latency : n/a.
// Backpres: n/a.
module tb_game_input_ctrl;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NB-1:0] key_n = '1;
  logic          uart_valid = 1'b0;
  logic [7:0]    uart_data = 8'h00;
  logic          turn_active = 1'b0;
  logic          win_flag = 1'b0;
  logic          move_left, move_right, move_made, times_up, game_reset;
  logic [NB-1:0] btn_pulse;
  logic [3:0]    turn_secs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  game_input_ctrl #(
    .CLK_HZ(10), .NUM_BTN(NB), .DEBOUNCE_CYC(4), .TURN_SEC(3), .WIN_DELAY_CYC(20), .UART_EN(1)
  ) dut (
    .clk(clk), .rstn(rstn), .key_n(key_n), .uart_valid(uart_valid), .uart_data(uart_data),
    .turn_active(turn_active), .win_flag(win_flag), .move_left(move_left), .move_right(move_right),
    .move_made(move_made), .times_up(times_up), .game_reset(game_reset), .btn_pulse(btn_pulse),
    .turn_secs(turn_secs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    n_tests++;
    if ({move_left, move_right, move_made, times_up, game_reset, btn_pulse, turn_secs} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0",
               {move_left, move_right, move_made, times_up, game_reset, btn_pulse, turn_secs});
    end
    rstn = 1'b1;
    idle(3);
    n_tests++;
    if ({move_left, move_right, move_made, times_up, game_reset, btn_pulse, turn_secs} !== 13'd0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got %b expected 0",
               {move_left, move_right, move_made, times_up, game_reset, btn_pulse, turn_secs});
    end
  endtask

  task automatic test_debounce();
    int made;
    key_n[2] = 1'b0;
    idle(3);
    key_n[2] = 1'b1;
    made = 0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      made += int'(move_made) + int'(btn_pulse != 0);
    end
    n_tests++;
    if (made !== 0) begin n_fail++; $display("FAIL debounce_glitch: got %0d pulses expected 0", made); end

    key_n[2] = 1'b0;
    made = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 7) begin
        n_tests++;
        if (btn_pulse !== 4'b0100) begin n_fail++; $display("FAIL debounce_btn_pulse: got %b expected 0100", btn_pulse); end
      end
      if (t == 8) begin
        n_tests++;
        if (move_made !== 1'b1) begin n_fail++; $display("FAIL debounce_move_at_8: got %b expected 1", move_made); end
        key_n[2] = 1'b1;
      end
      made += int'(move_made);
    end
    n_tests++;
    if (made !== 1) begin n_fail++; $display("FAIL debounce_single_pulse: got %0d expected 1", made); end
    idle(10);
  endtask

  task automatic test_timer();
    int made, tup;
    made = 0;
    tup  = 0;
    turn_active = 1'b1;
    for (int t = 1; t <= 31; t++) begin
      tick();
      made += int'(move_made);
      tup  += int'(times_up);
      if (t == 10 && turn_secs !== 4'd1) begin n_fail++; $display("FAIL timer_sec1: got %0d expected 1", turn_secs); end
      if (t == 20 && turn_secs !== 4'd2) begin n_fail++; $display("FAIL timer_sec2: got %0d expected 2", turn_secs); end
      if (t == 30 && {turn_secs, move_made, times_up} !== 6'b0011_11) begin
        n_fail++;
        $display("FAIL timer_timeout: got secs=%0d made=%b up=%b expected 3 1 1", turn_secs, move_made, times_up);
      end
      if (t == 31 && turn_secs !== 4'd0) begin n_fail++; $display("FAIL timer_cleared: got %0d expected 0", turn_secs); end
      if (t == 10 || t == 20 || t == 30 || t == 31) n_tests++;
    end
    turn_active = 1'b0;
    n_tests++;
    if (made !== 1 || tup !== 1) begin
      n_fail++;
      $display("FAIL timer_once: got made=%0d up=%0d expected 1 1", made, tup);
    end
  endtask

  task automatic test_uart();
    turn_active = 1'b1;
    idle(15);
    n_tests++;
    if (turn_secs !== 4'd1) begin n_fail++; $display("FAIL uart_pre_secs: got %0d expected 1", turn_secs); end

    uart_valid = 1'b1; uart_data = 8'h02;
    tick();
    uart_valid = 1'b0;
    n_tests++;
    if ({move_left, move_right, move_made, turn_secs} !== 7'b100_0001) begin
      n_fail++;
      $display("FAIL uart_left: got l=%b r=%b m=%b secs=%0d expected 1 0 0 1", move_left, move_right, move_made, turn_secs);
    end

    turn_active = 1'b0;
    idle(3);
    n_tests++;
    if ({move_left, turn_secs} !== 5'b0_0001) begin
      n_fail++;
      $display("FAIL uart_hold: got l=%b secs=%0d expected 0 1", move_left, turn_secs);
    end

    uart_valid = 1'b1; uart_data = 8'h03;
    tick();
    uart_valid = 1'b0;
    n_tests++;
    if ({move_made, times_up} !== 2'b10) begin
      n_fail++;
      $display("FAIL uart_accept: got made=%b up=%b expected 1 0", move_made, times_up);
    end
    tick();
    n_tests++;
    if ({move_made, turn_secs} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL uart_accept_clear: got made=%b secs=%0d expected 0 0", move_made, turn_secs);
    end

    turn_active = 1'b1;
    idle(9);
    n_tests++;
    if (turn_secs !== 4'd0) begin n_fail++; $display("FAIL uart_presc_cleared: got %0d expected 0", turn_secs); end
    tick();
    n_tests++;
    if (turn_secs !== 4'd1) begin n_fail++; $display("FAIL uart_presc_restart: got %0d expected 1", turn_secs); end

    uart_valid = 1'b1; uart_data = 8'h7F;
    tick();
    uart_valid = 1'b0;
    n_tests++;
    if ({move_left, move_right, move_made, times_up, game_reset} !== 5'b0) begin
      n_fail++;
      $display("FAIL uart_unknown: got %b expected 00000", {move_left, move_right, move_made, times_up, game_reset});
    end
    turn_active = 1'b0;
  endtask

  task automatic test_conflicts();
    int lr, rs, mm;
    key_n[1:0] = 2'b00;
    lr = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 7) begin
        n_tests++;
        if (btn_pulse !== 4'b0011) begin n_fail++; $display("FAIL conflict_lr_btn: got %b expected 0011", btn_pulse); end
      end
      if (t == 8) key_n[1:0] = 2'b11;
      lr += int'(move_left) + int'(move_right) + int'(move_made);
    end
    n_tests++;
    if (lr !== 0) begin n_fail++; $display("FAIL conflict_lr_dropped: got %0d pulses expected 0", lr); end
    idle(8);

    key_n[3] = 1'b0;
    rs = 0; mm = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      rs += int'(game_reset);
      mm += int'(move_made);
      if (t == 8) begin
        uart_valid = 1'b0;
        key_n[3] = 1'b1;
        n_tests++;
        if ({game_reset, move_made} !== 2'b10) begin
          n_fail++;
          $display("FAIL conflict_reset_wins: got rst=%b made=%b expected 1 0", game_reset, move_made);
        end
      end
      if (t == 7) begin uart_valid = 1'b1; uart_data = 8'h03; end
    end
    n_tests++;
    if (rs !== 1 || mm !== 0) begin n_fail++; $display("FAIL conflict_reset_count: got rst=%0d made=%0d expected 1 0", rs, mm); end
    idle(8);

    key_n[2] = 1'b0;
    mm = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      mm += int'(move_made);
      if (t == 8) begin
        uart_valid = 1'b0;
        key_n[2] = 1'b1;
        n_tests++;
        if (move_made !== 1'b1) begin n_fail++; $display("FAIL conflict_merge: got %b expected 1", move_made); end
      end
      if (t == 7) begin uart_valid = 1'b1; uart_data = 8'h03; end
    end
    n_tests++;
    if (mm !== 1) begin n_fail++; $display("FAIL conflict_merge_count: got %0d expected 1", mm); end
    idle(8);
  endtask

  task automatic test_win();
    int moves, stray;
    moves = 0; stray = 0;
    win_flag = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      tick();
      moves += int'(move_left) + int'(move_right) + int'(move_made);
      if (t == 20) begin
        n_tests++;
        if (game_reset !== 1'b1) begin n_fail++; $display("FAIL win_reset_at_20: got %b expected 1", game_reset); end
      end else begin
        stray += int'(game_reset);
      end
      if (t == 1) key_n[0] = 1'b0;
      if (t == 9) key_n[0] = 1'b1;
      if (t == 4) key_n[2] = 1'b0;
      if (t == 12) key_n[2] = 1'b1;
    end
    n_tests++;
    if (moves !== 0 || stray !== 0) begin
      n_fail++;
      $display("FAIL win_suppress: got moves=%0d stray_resets=%0d expected 0 0", moves, stray);
    end
    win_flag = 1'b0;
    idle(3);

    stray = 0;
    win_flag = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 9) begin
        n_tests++;
        if (game_reset !== 1'b1) begin n_fail++; $display("FAIL win_manual_at_9: got %b expected 1", game_reset); end
      end else begin
        stray += int'(game_reset);
      end
      if (t == 1) key_n[3] = 1'b0;
      if (t == 10) key_n[3] = 1'b1;
    end
    n_tests++;
    if (stray !== 0) begin n_fail++; $display("FAIL win_manual_cancel: got %0d extra resets expected 0", stray); end
    win_flag = 1'b0;
    idle(10);
  endtask

  task automatic test_async_reset();
    int pulses;
    win_flag = 1'b1;
    idle(10);
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({move_left, move_right, move_made, times_up, game_reset, btn_pulse, turn_secs} !== 13'd0) begin
      n_fail++;
      $display("FAIL arst_win_outputs: got %b expected 0",
               {move_left, move_right, move_made, times_up, game_reset, btn_pulse, turn_secs});
    end
    win_flag = 1'b0;
    idle(2);
    rstn = 1'b1;
    pulses = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      pulses += int'(game_reset);
    end
    n_tests++;
    if (pulses !== 0) begin n_fail++; $display("FAIL arst_no_late_reset: got %0d expected 0", pulses); end

    turn_active = 1'b1;
    idle(25);
    n_tests++;
    if (turn_secs !== 4'd2) begin n_fail++; $display("FAIL arst_pre_secs: got %0d expected 2", turn_secs); end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({move_left, move_right, move_made, times_up, game_reset, btn_pulse, turn_secs} !== 13'd0) begin
      n_fail++;
      $display("FAIL arst_timer_outputs: got %b expected 0",
               {move_left, move_right, move_made, times_up, game_reset, btn_pulse, turn_secs});
    end
    idle(2);
    n_tests++;
    if (turn_secs !== 4'd0) begin n_fail++; $display("FAIL arst_timer_held: got %0d expected 0", turn_secs); end
    turn_active = 1'b0;
    rstn = 1'b1;
    pulses = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      pulses += int'(game_reset) + int'(move_made) + int'(times_up) + int'(turn_secs != 4'd0);
    end
    n_tests++;
    if (pulses !== 0) begin n_fail++; $display("FAIL arst_quiet_after: got %0d events expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_timer();
    test_uart();
    test_conflicts();
    test_win();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
